// File: rtl/pulse_det_pkg.sv
// Shared types and constants for the multi-channel pulse width detector.
// Optional input synchroniser is enabled with PULSE_WIDTH_DET_SYNC_EN.
package pulse_det_pkg;

    typedef enum logic [1:0] {
        WAIT,
        IDLE,
        ACT,
        OVER
    } pd_state_e;

    localparam int DEF_CNT_W  = 8;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/pulse_width_channel.sv
// One channel: FSM, width counter and registered strobes/width.
// Takes the already-normalised level x (1 = active).
module pulse_width_channel
    import pulse_det_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic [CNT_W-1:0] min_len,
    input  logic [CNT_W-1:0] max_len,
    output logic             detected,
    output logic             too_long,
    output logic [CNT_W-1:0] pulse_len
);

    pd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_d;
    logic [CNT_W-1:0] eff_min;
    logic             det_d, tl_d;
    logic             in_win;
    logic             cnt_full;

    assign eff_min  = (min_len == '0) ? CNT_W'(1) : min_len;
    assign in_win   = (cnt_q >= eff_min) && (cnt_q <= max_len);
    assign cnt_full = &cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        det_d   = 1'b0;
        tl_d    = 1'b0;
        len_d   = pulse_len;
        unique case (state_q)
            WAIT: begin
                if (!x) state_d = IDLE;
            end
            IDLE: begin
                if (x) begin
                    cnt_d = CNT_W'(1);
                    if (max_len == '0) begin
                        state_d = OVER;
                        tl_d    = 1'b1;
                    end else begin
                        state_d = ACT;
                    end
                end
            end
            ACT: begin
                if (x) begin
                    if (cnt_q == max_len) begin
                        state_d = OVER;
                        tl_d    = 1'b1;
                    end else if (!cnt_full) begin
                        // max_len lowered mid-pulse must not let cnt wrap
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    if (in_win) begin
                        det_d = 1'b1;
                        len_d = cnt_q;
                    end
                end
            end
            OVER: begin
                if (!x) state_d = IDLE;
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT;
            cnt_q     <= '0;
            detected  <= 1'b0;
            too_long  <= 1'b0;
            pulse_len <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            detected  <= det_d;
            too_long  <= tl_d;
            pulse_len <= len_d;
        end
    end

endmodule

// File: rtl/multi_channel_pulse_width_detector.sv
// N_CH independent pulse width detectors with a shared accept window.
// Define PULSE_WIDTH_DET_SYNC_EN to add a two-flop synchroniser per input.
module multi_channel_pulse_width_detector
    import pulse_det_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       a,
    input  logic [N_CH-1:0]       pol,
    input  logic [CNT_W-1:0]      min_len,
    input  logic [CNT_W-1:0]      max_len,
    output logic [N_CH-1:0]       detected,
    output logic [N_CH-1:0]       too_long,
    output logic [N_CH*CNT_W-1:0] pulse_len
);

    logic [N_CH-1:0] x;

`ifdef PULSE_WIDTH_DET_SYNC_EN
    logic [N_CH-1:0] sync_q [SYNC_DEPTH];

    // Flops reset to the inactive level so reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < SYNC_DEPTH; d++) sync_q[d] <= pol;
        end else begin
            sync_q[0] <= a;
            for (int d = 1; d < SYNC_DEPTH; d++) sync_q[d] <= sync_q[d-1];
        end
    end

    assign x = sync_q[SYNC_DEPTH-1] ^ pol;
`else
    assign x = a ^ pol;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_width_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .x        (x[i]),
            .min_len  (min_len),
            .max_len  (max_len),
            .detected (detected[i]),
            .too_long (too_long[i]),
            .pulse_len(pulse_len[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/multi_channel_pulse_width_detector.md
# multi_channel_pulse_width_detector

Parametrised successor to the single-bit edge and pulse detectors in the sequential-basics set. It monitors `N_CH` independent input lines and measures the width, in clock cycles, of each active pulse. It flags a pulse when its width falls inside a runtime window [`min_len`, `max_len`] and separately flags pulses that overrun `max_len`. It sits after the input sampling stage and feeds registered one-cycle strobes and captured widths to downstream control logic.

## Interface
- `N_CH`, default 4: number of independent channels.
- `CNT_W`, default 8: width of the length counter and of the `min_len`/`max_len` ports.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `a` input, `N_CH` bits: monitored lines, one bit per channel.
- `pol` input, `N_CH` bits: per-channel active level. 0 means active-high pulses; 1 means active-low pulses.
- `min_len` input, `CNT_W` bits: minimum accepted width, shared by all channels.
- `max_len` input, `CNT_W` bits: maximum accepted width, shared by all channels.
- `detected` output, `N_CH` bits: registered one-cycle strobe per channel for an accepted pulse.
- `too_long` output, `N_CH` bits: registered one-cycle strobe per channel for a pulse that exceeded `max_len`.
- `pulse_len` output, `N_CH*CNT_W` bits: the width of the last accepted pulse. Channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Normalised level per channel: x = a[i] ^ pol[i]. x = 1 means active.
- Each channel runs its own FSM with states WAIT, IDLE, ACT and OVER, plus a `CNT_W`-bit counter `cnt`.
- WAIT is the reset state. A pulse already in progress at reset is never measured.
  - x = 0: go to IDLE.
  - x = 1: stay in WAIT.
- IDLE:
  - x = 1: go to ACT and load `cnt` = 1.
  - x = 0: stay in IDLE.
- ACT with x = 1:
  - If `cnt` == `max_len`: go to OVER and pulse `too_long` for one cycle.
  - Otherwise: `cnt` = `cnt` + 1.
- ACT with x = 0: go to IDLE.
  - If eff_min <= `cnt` <= `max_len`: pulse `detected` for one cycle and set `pulse_len` = `cnt`.
  - Otherwise: the pulse is dropped silently.
- OVER:
  - x = 0: go to IDLE with no strobe.
  - x = 1: stay in OVER. `cnt` holds its value and never wraps.
- eff_min = max(`min_len`, 1), so `min_len` = 0 behaves as 1.
- `max_len` = 0: the first active sample goes directly from IDLE to OVER and `too_long` strobes on that edge.
- `max_len` < eff_min: no pulse is ever accepted. `too_long` still operates.
- `min_len`, `max_len` and `pol` are read on every edge with no shadowing. A change mid-pulse takes effect at the next evaluating edge.
- Back-to-back pulses need only one inactive sample between them. A pulse may end on the same edge that a strobe for the previous pulse is output.
- Channels are fully independent. Simultaneous strobes on several channels are legal.

## Timing
- Reset values while `rst_n` = 0: `detected` = 0, `too_long` = 0, `pulse_len` = 0, all FSMs in WAIT, all `cnt` = 0. Reset applies immediately, without waiting for a clock edge.
- Reset asserted mid-pulse: the pulse is discarded. After release the channel must see x = 0 before it arms.
- Latency for a pulse whose last active sample is at edge E: `detected` is high from edge E+1 to edge E+2.
- Latency for an overrun: `too_long` is high for the cycle after the edge at which x = 1 is sampled with `cnt` == `max_len`.
- `pulse_len` updates on the same edge that `detected` rises and holds until the next accepted pulse.
- Width: a pulse sampled active on n consecutive edges has width n.

## Configuration
- Macro `PULSE_WIDTH_DET_SYNC_EN`.
- Defined: each `a` bit passes through a two-flop synchroniser before the FSM. The synchroniser flops reset to the inactive level, i.e. to `pol`. All latencies grow by 2 cycles.
- Undefined: `a` feeds the FSM directly and the latencies above apply as stated.

## Structure
- Package `pulse_det_pkg` holds:
  - the state enum typedef: WAIT, IDLE, ACT, OVER;
  - default `CNT_W`;
  - a `localparam` for the synchroniser depth, 2.
- Sub-module `pulse_width_channel` holds one FSM, counter and output registers. The top module instantiates it `N_CH` times in a generate loop.

## Test plan
- Single-cycle pulse:
  - Stimulus: `min_len` = `max_len` = 1, `pol` = 0, `a[0]` high for 1 cycle.
  - Required: `detected[0]` high for 1 cycle, 1 cycle after the fall; `pulse_len[0]` = 1.
  - Stimulus: the same with `a[0]` high for 2 cycles.
  - Required: `too_long[0]` strobes; no `detected`.
- Window:
  - Stimulus: `min_len` = 3, `max_len` = 5, pulses of width 2, 3, 5 and 6 on channel 1.
  - Required: `detected` only for widths 3 and 5, with `pulse_len` = 3 and then 5. A `too_long` strobe for width 6, on the edge where the 6th active sample is seen.
- Polarity:
  - Stimulus: `pol[2]` = 1, `a[2]` idles high, then goes low for 4 cycles with `min_len` = 1, `max_len` = 8.
  - Required: `detected[2]` strobes with `pulse_len` = 4.
- Reset and WAIT:
  - Stimulus: `a[3]` high before and through `rst_n` release, then low, then high for 2 cycles.
  - Required: the first pulse is ignored; the second is detected with `pulse_len` = 2.
- Reset mid-pulse and saturation:
  - Stimulus: `rst_n` pulsed low during a width-3 pulse.
  - Required: all outputs are 0 immediately and no strobe follows.
  - Stimulus: `CNT_W` = 4, `max_len` = 15, input held active for 40 cycles.
  - Required: exactly one `too_long` strobe; `cnt` never wraps.
- Multi-channel simultaneity:
  - Stimulus: identical width-2 pulses on all 4 channels in the same cycles.
  - Required: `detected` = 4'b1111 for one cycle.
  - Stimulus: the same with `PULSE_WIDTH_DET_SYNC_EN` defined.
  - Required: the strobe arrives 2 cycles later.
